// File: rtl/sha256_msg_schedule.sv
// SHA-256 message schedule: loads 16 words, emits W0..W(ROUNDS-1) from a 16-word circular buffer.
// Define SHA256_MSG_BYTESWAP_EN to byte-reverse in_word on load (little-endian byte-stream sources).
module sha256_msg_schedule #(
    parameter int ROUNDS = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in_word,
    input  logic        in_valid,
    output logic        in_ready,
    output logic [31:0] out_Wi,
    output logic [5:0]  out_round_n,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        out_last,
    output logic        busy
);
    typedef enum logic {S_LOAD, S_EMIT} state_t;
    localparam logic [5:0] LAST_T = 6'(ROUNDS - 1);

    state_t      state_q;
    logic [3:0]  lc_q;
    logic [5:0]  t_q;
    logic        in_ready_q;
    logic        out_valid_q;
    logic        out_last_q;
    logic        busy_q;
    logic [31:0] msg_buf_q [16];

    logic        accept;
    logic        hshk;
    logic        expand;
    logic [3:0]  idx_1;
    logic [3:0]  idx_9;
    logic [3:0]  idx_14;
    logic [31:0] word_in;
    logic [31:0] w_new;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

`ifdef SHA256_MSG_BYTESWAP_EN
    assign word_in = {in_word[7:0], in_word[15:8], in_word[23:16], in_word[31:24]};
`else
    assign word_in = in_word;
`endif

    assign accept = in_valid && in_ready_q;
    assign hshk   = out_valid_q && out_ready;
    assign expand = (t_q[5:4] != 2'b00);

    // 4-bit index arithmetic wraps mod 16, matching the circular buffer slots for t-2, t-7, t-15, t-16.
    assign idx_1  = t_q[3:0] + 4'd1;
    assign idx_9  = t_q[3:0] + 4'd9;
    assign idx_14 = t_q[3:0] + 4'd14;
    assign w_new  = sig1(msg_buf_q[idx_14]) + msg_buf_q[idx_9]
                  + sig0(msg_buf_q[idx_1]) + msg_buf_q[t_q[3:0]];

    assign out_Wi      = expand ? w_new : msg_buf_q[t_q[3:0]];
    assign out_round_n = t_q;
    assign out_valid   = out_valid_q;
    assign out_last    = out_last_q;
    assign in_ready    = in_ready_q;
    assign busy        = busy_q;

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (accept) begin
                msg_buf_q[lc_q] <= word_in;
            end else if (hshk && expand) begin
                msg_buf_q[t_q[3:0]] <= w_new;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_LOAD;
            lc_q        <= 4'd0;
            t_q         <= 6'd0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                S_LOAD: begin
                    if (accept) begin
                        busy_q <= 1'b1;
                        if (lc_q == 4'd15) begin
                            lc_q        <= 4'd0;
                            t_q         <= 6'd0;
                            state_q     <= S_EMIT;
                            in_ready_q  <= 1'b0;
                            out_valid_q <= 1'b1;
                            out_last_q  <= 1'b0;
                        end else begin
                            lc_q <= lc_q + 4'd1;
                        end
                    end
                end
                S_EMIT: begin
                    if (hshk) begin
                        if (t_q == LAST_T) begin
                            state_q     <= S_LOAD;
                            t_q         <= 6'd0;
                            in_ready_q  <= 1'b1;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            busy_q      <= 1'b0;
                        end else begin
                            t_q        <= t_q + 6'd1;
                            out_last_q <= ((t_q + 6'd1) == LAST_T);
                        end
                    end
                end
                default: state_q <= S_LOAD;
            endcase
        end
    end
endmodule
